alu_result_stage: RTL

- Registered output stage directly downstream of the 32-bit bitwise units (and_32bit, or/xor) and the 32-bit adder/subtractor.
- Selects the final ALU result by a 3-bit opcode and derives the zero, carryout and overflow flags.
- Presents the result through a valid/ready handshake backed by a 2-entry skid buffer, so the combinational ALU front end is isolated from a stalling consumer.

---
 rtl/alu_result_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// Registered ALU result/flag select stage with a 2-entry skid buffer on a valid/ready output.
// Define ALU_RESULT_STATS_EN to add saturating transfer and zero-result counters.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] and_res,
  input  logic [WIDTH-1:0] or_res,
  input  logic [WIDTH-1:0] xor_res,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry_in_flag,
  input  logic             ovf_in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carryout,
  output logic             overflow
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0]      result_count,
  output logic [15:0]      zero_count
`endif
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             cout;
    logic             ovf;
  } entry_t;

  function automatic logic [WIDTH-1:0] select_result(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] f_and,
    input logic [WIDTH-1:0] f_or,
    input logic [WIDTH-1:0] f_xor,
    input logic [WIDTH-1:0] f_sum,
    input logic             f_ovf
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (f_op)
      OP_ADD, OP_SUB: r = f_sum;
      OP_XOR:         r = f_xor;
      // Signed less-than from the upstream subtraction: sign corrected by overflow.
      OP_SLT:         r[0] = f_sum[WIDTH-1] ^ f_ovf;
      OP_AND:         r = f_and;
      OP_NAND:        r = ~f_and;
      OP_NOR:         r = ~f_or;
      default:        r = f_or;
    endcase
    return r;
  endfunction

`ifdef ALU_RESULT_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  entry_t main_q, main_d, skid_q, skid_d, new_entry;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   accept, xfer, arith;

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & in_ready;
  assign xfer     = main_vld_q & out_ready;
  assign arith    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);

  always_comb begin
    new_entry.res  = select_result(op, and_res, or_res, xor_res, sum, ovf_in_flag);
    new_entry.zero = (new_entry.res == '0);
    new_entry.cout = arith & carry_in_flag;
    new_entry.ovf  = arith & ovf_in_flag;
  end

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || xfer) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = new_entry;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end
    // Main is occupied and not draining: park the new entry in the skid slot.
    if (accept && main_vld_q && !xfer) begin
      skid_d     = new_entry;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid = main_vld_q;
  assign result    = main_q.res;
  assign zero      = main_q.zero;
  assign carryout  = main_q.cout;
  assign overflow  = main_q.ovf;

`ifdef ALU_RESULT_STATS_EN
  logic [15:0] res_cnt_q, res_cnt_d, zero_cnt_q, zero_cnt_d;

  always_comb begin
    res_cnt_d  = res_cnt_q;
    zero_cnt_d = zero_cnt_q;
    if (xfer) begin
      res_cnt_d = sat_inc(res_cnt_q);
      if (main_q.zero) zero_cnt_d = sat_inc(zero_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_cnt_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      res_cnt_q  <= res_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign result_count = res_cnt_q;
  assign zero_count   = zero_cnt_q;
`endif

endmodule
